sram_like_arb_2x1: RTL

- Two-requester arbiter that shares one SRAM-like master port (req/wr/size/addr/wdata, addr_ok/data_ok/rdata) between the instruction-cache miss path (port I) and the data path (port D).
- Sits between the cache/bridge layer and the CPU-to-AXI interface, so a single SRAM-like channel can serve both sides.
- Exactly one transaction is outstanding at a time.
- D has fixed priority; a starvation limiter guarantees I forward progress.

---
 rtl/sram_like_arb_2x1_if.sv | 53 +++++
 rtl/sram_like_arb_2x1.sv | 97 +++++++++
 2 files changed

// File: rtl/sram_like_arb_2x1_if.sv
// SRAM-like bundle for the 2x1 arbiter: requester ports I and D, the shared master port, and status.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface sram_like_arb_2x1_if;
   logic        i_req;
   logic        i_wr;
   logic [1:0]  i_size;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        i_addr_ok;
   logic        i_data_ok;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_wr;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_addr_ok;
   logic        d_data_ok;
   logic [31:0] d_rdata;

   logic        m_req;
   logic        m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_addr_ok;
   logic        m_data_ok;
   logic [31:0] m_rdata;

   logic        busy;
   logic        owner;

   modport slave (
      input  i_req, i_wr, i_size, i_addr, i_wdata,
      output i_addr_ok, i_data_ok, i_rdata,
      input  d_req, d_wr, d_size, d_addr, d_wdata,
      output d_addr_ok, d_data_ok, d_rdata,
      output m_req, m_wr, m_size, m_addr, m_wdata,
      input  m_addr_ok, m_data_ok, m_rdata,
      output busy, owner
   );

   modport master (
      output i_req, i_wr, i_size, i_addr, i_wdata,
      input  i_addr_ok, i_data_ok, i_rdata,
      output d_req, d_wr, d_size, d_addr, d_wdata,
      input  d_addr_ok, d_data_ok, d_rdata,
      input  m_req, m_wr, m_size, m_addr, m_wdata,
      output m_addr_ok, m_data_ok, m_rdata,
      input  busy, owner
   );
endinterface

// File: rtl/sram_like_arb_2x1.sv
// Two-requester arbiter sharing one SRAM-like master port; D has fixed priority, I is protected
// from starvation by a saturating counter of D grants issued while I was waiting.
//
// state | meaning
// IDLE  | no transaction; arbitrate and present the winner combinationally
// ADDR  | request presented, waiting for m_addr_ok
// DATA  | address accepted, waiting for m_data_ok
module sram_like_arb_2x1 #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic               aclk,
   input  logic               aresetn,
   sram_like_arb_2x1_if.slave bus
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t     r_state;
   logic       r_owner;
   logic [3:0] r_starve_cnt;

   logic w_grant_i;
   logic w_grant_d;
   logic w_grant;
   logic w_sel_d;
   logic w_m_req;
   logic w_data_ok;

   always_comb begin
      w_grant_i = bus.i_req && (!bus.d_req || (r_starve_cnt == LIMIT));
      w_grant_d = !w_grant_i && bus.d_req;
      w_grant   = w_grant_i || w_grant_d;
      w_sel_d   = (r_state == IDLE) ? w_grant_d : r_owner;
      w_m_req   = ((r_state == IDLE) && w_grant) || (r_state == ADDR);
      w_data_ok = (r_state == DATA) && bus.m_data_ok;
   end

   always_comb begin
      bus.m_req   = w_m_req;
      bus.m_wr    = 1'b0;
      bus.m_size  = 2'd0;
      bus.m_addr  = 32'd0;
      bus.m_wdata = 32'd0;
      if (w_m_req) begin
         bus.m_wr    = w_sel_d ? bus.d_wr    : bus.i_wr;
         bus.m_size  = w_sel_d ? bus.d_size  : bus.i_size;
         bus.m_addr  = w_sel_d ? bus.d_addr  : bus.i_addr;
         bus.m_wdata = w_sel_d ? bus.d_wdata : bus.i_wdata;
      end
   end

   // Non-owner handshakes stay low; stray master handshakes outside their phase are dropped.
   always_comb begin
      bus.i_addr_ok = w_m_req && bus.m_addr_ok && !w_sel_d;
      bus.d_addr_ok = w_m_req && bus.m_addr_ok &&  w_sel_d;
      bus.i_data_ok = w_data_ok && !r_owner;
      bus.d_data_ok = w_data_ok &&  r_owner;
      bus.i_rdata   = bus.i_data_ok ? bus.m_rdata : 32'd0;
      bus.d_rdata   = bus.d_data_ok ? bus.m_rdata : 32'd0;
      bus.busy      = (r_state != IDLE);
      bus.owner     = w_sel_d;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_starve_cnt <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_owner <= w_grant_d;
                  r_state <= bus.m_addr_ok ? DATA : ADDR;
                  if (w_grant_d && bus.i_req) begin
                     if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 4'd1;
                  end else begin
                     r_starve_cnt <= 4'd0;
                  end
               end
            end
            ADDR: begin
               if (bus.m_addr_ok) r_state <= DATA;
            end
            DATA: begin
               if (bus.m_data_ok) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
